generate_burst_len: RTL and testbench

Inverse of the last-flag generator. Consumes a per-beat stream of last flags and emits one burst length (beats − 1) per completed burst. Sits on the write-response/monitor side of the memory-mapped adapters, where beat streams are regrouped into bursts for request accounting. Bursts longer than 2^BurstLenWidth beats are split automatically, and a sticky status bit records that this happened.

---
 rtl/generate_burst_len.sv | 48 ++++
 tb/tb_generate_burst_len.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/generate_burst_len.sv
// Regroups a per-beat stream of last flags into burst lengths (beats - 1).
// Ports: clk/rst, last_* input FIFO pop side, burst_len_* output FIFO push side, split status.
module generate_burst_len #(
  parameter int BurstLenWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     last_dout,
  input  logic                     last_empty_n,
  output logic                     last_read,
  output logic [BurstLenWidth-1:0] burst_len_din,
  input  logic                     burst_len_full_n,
  output logic                     burst_len_write,
  output logic                     split
);

  logic [BurstLenWidth-1:0] count;
  logic                     max;
  logic                     closes;

  // A full counter forces the current beat to close the burst,
  // so the counter can never wrap.
  assign max    = &count;
  assign closes = last_dout | max;

  // Non-closing beats never need output space; closing beats wait for it.
  assign last_read       = ~rst & last_empty_n & (burst_len_full_n | ~closes);
  assign burst_len_write = last_read & closes;
  assign burst_len_din   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      split <= 1'b0;
    end else if (last_read) begin
      if (closes) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      // Only a forced close marks a split; a genuine last at max does not.
      if (max & ~last_dout) begin
        split <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_generate_burst_len.sv
// Scoreboard bench for generate_burst_len with a small-width instance.
// Driver models the input FIFO; monitor checks every emitted burst length.
module tb_generate_burst_len;

  localparam int W = 2;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         last_dout = 1'b0;
  logic         last_empty_n = 1'b0;
  logic         last_read;
  logic [W-1:0] burst_len_din;
  logic         burst_len_full_n = 1'b1;
  logic         burst_len_write;
  logic         split;

  int checks = 0;
  int errors = 0;

  bit bq[$];
  int eq[$];
  bit exp_split = 1'b0;

  generate_burst_len #(.BurstLenWidth(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .last_dout        (last_dout),
    .last_empty_n     (last_empty_n),
    .last_read        (last_read),
    .burst_len_din    (burst_len_din),
    .burst_len_full_n (burst_len_full_n),
    .burst_len_write  (burst_len_write),
    .split            (split)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst of n beats becomes full-size pieces of M beats
  // while more than M beats remain, then one final piece.
  task automatic push_burst(input int n);
    int rem;
    for (int i = 0; i < n; i++) bq.push_back(i == n - 1);
    rem = n;
    while (rem > M) begin
      eq.push_back(M - 1);
      rem -= M;
      exp_split = 1'b1;
    end
    eq.push_back(rem - 1);
  endtask

  // Monitor: pops the expected length whenever the DUT writes.
  always @(negedge clk) begin
    if (burst_len_write) begin
      chk("write_while_full", int'(burst_len_full_n), 1);
      if (eq.size() == 0) begin
        chk("unexpected_write", int'(burst_len_din), -1);
      end else begin
        chk("burst_len", int'(burst_len_din), eq.pop_front());
      end
    end
  end

  task automatic step(input bit gaps, input bit fn, output bit rd, output bit wr);
    last_empty_n = (bq.size() > 0) && (!gaps || $urandom_range(1, 0) == 1);
    last_dout = (bq.size() > 0) ? bq[0] : 1'($urandom_range(1, 0));
    burst_len_full_n = fn;
    @(negedge clk);
    rd = last_read;
    wr = burst_len_write;
    if (rd) begin
      chk("read_while_empty", int'(last_empty_n), 1);
      if (bq.size() > 0) void'(bq.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    last_empty_n = 1'b1;
    last_dout = 1'b1;
    burst_len_full_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_read", int'(last_read), 0);
      chk("rst_no_write", int'(burst_len_write), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_empty_n = 1'b0;
    bq.delete();
    exp_split = 1'b0;
    chk("rst_split", int'(split), 0);
    chk("rst_din", int'(burst_len_din), 0);
  endtask

  task automatic idle(input int n);
    bit rd, wr;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, rd, wr);
  endtask

  initial begin
    bit rd, wr;
    int cyc;

    do_reset();

    // Two bursts back to back, one beat per cycle.
    push_burst(4);
    push_burst(1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, rd, wr);
      chk("t1_read", int'(rd), 1);
    end
    idle(2);
    chk("t1_drained", eq.size(), 0);
    chk("t1_split", int'(split), 0);

    // Seven-beat burst forced to split after four beats.
    do_reset();
    push_burst(7);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, rd, wr);
      chk("t2_read", int'(rd), 1);
      chk("t2_split", int'(split), int'(k >= 4));
    end
    idle(2);
    chk("t2_drained", eq.size(), 0);
    chk("t2_split_sticky", int'(split), 1);

    // Exactly maximum-length burst: no split.
    do_reset();
    push_burst(4);
    idle(6);
    chk("t3_drained", eq.size(), 0);
    chk("t3_split", int'(split), 0);

    // Closing beat stalls on a full output FIFO.
    do_reset();
    push_burst(3);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, rd, wr);
      chk("t4_open_read", int'(rd), 1);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, rd, wr);
      chk("t4_stall_read", int'(rd), 0);
      chk("t4_stall_write", int'(wr), 0);
    end
    step(1'b0, 1'b1, rd, wr);
    chk("t4_close_read", int'(rd), 1);
    chk("t4_close_write", int'(wr), 1);
    chk("t4_drained", eq.size(), 0);

    // Reset mid-burst discards the partial burst.
    do_reset();
    bq.push_back(1'b0);
    bq.push_back(1'b0);
    idle(2);
    do_reset();
    push_burst(2);
    idle(4);
    chk("t6_drained", eq.size(), 0);
    chk("t6_split", int'(split), 0);

    // Random bursts with input gaps and output back-pressure.
    do_reset();
    begin
      int total = 0;
      while (total < 200) begin
        int n = $urandom_range(10, 1);
        push_burst(n);
        total += n;
      end
    end
    cyc = 0;
    while (bq.size() > 0 && cyc < 5000) begin
      step(1'b1, $urandom_range(3, 0) != 0, rd, wr);
      cyc++;
    end
    chk("t5_input_drained", bq.size(), 0);
    idle(3);
    chk("t5_output_drained", eq.size(), 0);
    chk("t5_split", int'(split), int'(exp_split));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
